// File: rtl/nibble_array_packer_if.sv
// Handshake bundle between a nibble producer, the packer and a word consumer.
// Ports: in_valid/in_ready/in_nibble/in_last (nibble side), out_valid/out_ready/
//        out_data/out_count (word side), out_parity only with PACKER_PARITY_EN.
// master = nibble producer / word consumer side, slave = the packer itself.
interface nibble_array_packer_if #(
  parameter int LANES = 4
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_nibble;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;
  logic [3:0]           out_count;
`ifdef PACKER_PARITY_EN
  logic [LANES-1:0]     out_parity;
`endif

`ifdef PACKER_PARITY_EN
  modport master (
    output in_valid, in_nibble, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_parity
  );
  modport slave (
    input  in_valid, in_nibble, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_parity
  );
`else
  modport master (
    output in_valid, in_nibble, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );
  modport slave (
    input  in_valid, in_nibble, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
`endif

endinterface

// File: rtl/nibble_array_packer.sv
// Packs a stream of 4-bit nibbles into LANES-byte words; in_last closes a word early
// and fills the remaining nibble positions with PAD_NIBBLE.
// Latency: out_valid rises the cycle after the completing nibble is accepted.
// Backpressure: while a word is held and out_ready=0, in_ready is 0; a drain and a
// new nibble may transfer on the same edge, so throughput is one nibble per cycle.
// Ports: clk, reset (async, active-high), bus (nibble_array_packer_if.slave).
// Optional feature: define PACKER_PARITY_EN to add bus.out_parity (per-byte XOR).
module nibble_array_packer #(
  parameter int         LANES      = 4,     // 1..8 bytes per output word
  parameter logic [3:0] PAD_NIBBLE = 4'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  nibble_array_packer_if.slave   bus
);

  localparam int NIBS = 2 * LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [8*LANES-1:0] data_q,  data_d;
  // Nibble count needs 5 bits internally; LANES=8 full word (16) wraps to 0 on
  // the 4-bit out_count port.
  logic [4:0]         cnt_q,   cnt_d;
  logic [4:0]         pos;
  logic               in_rdy;
  logic               in_xfer;
  logic               out_xfer;

  // Held low during reset so nothing is accepted while state is being cleared.
  assign in_rdy   = !reset && ((state_q != HOLD) || bus.out_ready);
  assign in_xfer  = bus.in_valid && in_rdy;
  assign out_xfer = (state_q == HOLD) && bus.out_ready;

  // From IDLE or HOLD the incoming nibble always starts a fresh word.
  assign pos = (state_q == FILL) ? cnt_q : 5'd0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    if (out_xfer) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
    end

    if (in_xfer) begin
      if (state_q != FILL) begin
        data_d = '0;
      end
      for (int i = 0; i < NIBS; i++) begin
        if (5'(i) == pos) begin
          data_d[4*i +: 4] = bus.in_nibble;
        end else if (bus.in_last && (5'(i) > pos)) begin
          data_d[4*i +: 4] = PAD_NIBBLE;
        end
      end
      cnt_d = pos + 5'd1;
      if (bus.in_last || (pos == 5'(NIBS - 1))) begin
        state_d = HOLD;
      end else begin
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_count = cnt_q[3:0];

`ifdef PACKER_PARITY_EN
  // Derived from the data register, so it is stable with out_data and 0 in reset.
  always_comb begin
    bus.out_parity = '0;
    for (int k = 0; k < LANES; k++) begin
      bus.out_parity[k] = ^data_q[8*k +: 8];
    end
  end
`endif

endmodule

// File: tb/tb_nibble_array_packer.sv
module tb_nibble_array_packer;

  logic clk;
  logic reset;
  int   tests  = 0;
  int   errors = 0;
  int   cyc    = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic        hold_vld = 1'b0;
  logic [35:0] hold_val = '0;

  nibble_array_packer_if #(.LANES(4)) bus ();

  nibble_array_packer #(
    .LANES      (4),
    .PAD_NIBBLE (4'hF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every drained word, and checks held words stay put.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_word: got data=%h count=%0d expected none",
                   bus.out_data, bus.out_count);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_data", 64'(bus.out_data), 64'(mon_e.data));
          check("sb_count", 64'(bus.out_count), 64'(mon_e.cnt));
        end
        hold_vld = 1'b0;
      end else begin
        if (hold_vld) check("hold_stable", 64'({bus.out_data, bus.out_count}), 64'(hold_val));
        hold_vld = 1'b1;
        hold_val = {bus.out_data, bus.out_count};
      end
    end else begin
      hold_vld = 1'b0;
    end
  end

  task automatic send(input logic [3:0] n, input logic last);
    int waited = 0;
    bus.in_valid  = 1'b1;
    bus.in_nibble = n;
    bus.in_last   = last;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      tests++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b expected 1 within 50 cycles", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL drain_timeout: %0d words pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start;
    logic [3:0] w1 [8];
    logic [3:0] w4 [8];
    logic [3:0] w5 [8];
    w1 = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    w4 = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
    w5 = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_nibble = 4'h0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #1 reset = 1'b1;
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Full word, back-to-back, latency and throughput
    bus.out_ready = 1'b1;
    exp_q.push_back('{data: 32'h87654321, cnt: 4'd8});
    start = cyc;
    for (int i = 0; i < 7; i++) send(w1[i], 1'b0);
    check("pre_complete_valid", 64'(bus.out_valid), 64'd0);
    send(w1[7], 1'b0);
    check("latency_valid", 64'(bus.out_valid), 64'd1);
    check("throughput_cycles", 64'(cyc - start), 64'd8);
    wait_drain();

    // Early completion with padding
    exp_q.push_back('{data: 32'hFFFFFF1D, cnt: 4'd2});
    send(4'hD, 1'b0);
    send(4'h1, 1'b1);
    wait_drain();
    check("drained_valid", 64'(bus.out_valid), 64'd0);
    check("drained_count", 64'(bus.out_count), 64'd0);

    // Inputs ignored without in_valid
    bus.in_nibble = 4'hF;
    bus.in_last   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ignore_valid", 64'(bus.out_valid), 64'd0);
      check("ignore_count", 64'(bus.out_count), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.in_last = 1'b0;

    // Backpressure in HOLD, then drain with simultaneous fresh nibble
    bus.out_ready = 1'b0;
    exp_q.push_back('{data: 32'h0FEDCBA9, cnt: 4'd8});
    for (int i = 0; i < 8; i++) send(w4[i], 1'b0);
    bus.in_valid  = 1'b1;
    bus.in_nibble = 4'hA;
    bus.in_last   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_data", 64'(bus.out_data), 64'h0FEDCBA9);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    exp_q.push_back('{data: 32'h6543210A, cnt: 4'd8});
    send(4'hA, 1'b0);
    check("no_bubble_count", 64'(bus.out_count), 64'd1);
    check("no_bubble_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 7; i++) send(4'(i), 1'b0);
    wait_drain();

    // Reset mid-word discards held nibbles
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    check("midword_count", 64'(bus.out_count), 64'd3);
    #2 reset = 1'b1;
    #1;
    check("midrst_out_data", 64'(bus.out_data), 64'd0);
    check("midrst_out_count", 64'(bus.out_count), 64'd0);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back('{data: 32'h12345678, cnt: 4'd8});
    for (int i = 0; i < 8; i++) send(w5[i], 1'b0);
    wait_drain();

`ifdef PACKER_PARITY_EN
    // Per-byte parity
    bus.out_ready = 1'b0;
    exp_q.push_back('{data: 32'h0103FF07, cnt: 4'd8});
    send(4'h7, 1'b0); send(4'h0, 1'b0); send(4'hF, 1'b0); send(4'hF, 1'b0);
    send(4'h3, 1'b0); send(4'h0, 1'b0); send(4'h1, 1'b0); send(4'h0, 1'b0);
    @(negedge clk);
    check("parity", 64'(bus.out_parity), 64'b1001);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();
`endif

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
